switch_xbar_scheduler: RTL and testbench

Central crossbar scheduler for the 4-port switch. Takes the head-of-line packet of each input port FIFO, arbitrates each output port round-robin among the inputs that target it, and drives registered output beats. A multicast packet is popped from its FIFO only after every targeted output has accepted it. It sits between the four per-port input FIFOs and the four output port interfaces.

---
 rtl/switch_xbar_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_switch_xbar_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_xbar_scheduler.sv
// Central 4-port crossbar scheduler: per-output round-robin grants,
// registered output beats, multicast pop after the last target is served.
module switch_xbar_scheduler #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_target,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
    output logic [NUM_PORTS-1:0]          pop,
    output logic [NUM_PORTS-1:0]          out_valid,
    input  logic [NUM_PORTS-1:0]          out_ready,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic [2*NUM_PORTS-1:0]        out_src,
    output logic [15:0]                   drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        POPWAIT = 2'd2
    } in_state_t;

    in_state_t            state_q  [NUM_PORTS];
    in_state_t            state_d  [NUM_PORTS];
    logic [NUM_PORTS-1:0] remain_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] remain_d [NUM_PORTS];
    logic [1:0]           ptr_q    [NUM_PORTS];

    logic [NUM_PORTS-1:0] eff_req  [NUM_PORTS];
    logic [NUM_PORTS-1:0] col_req  [NUM_PORTS];
    logic [NUM_PORTS-1:0] granted  [NUM_PORTS];
    logic [1:0]           gnt_idx  [NUM_PORTS];
    logic [DATA_W-1:0]    gnt_data [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_any;
    logic [NUM_PORTS-1:0] out_free;
    logic [2:0]           drop_n;
    logic [16:0]          drop_sum;

    // Search starts just after the last winner; first hit wins.
    function automatic logic [2:0] rr_pick(
        input logic [3:0] req,
        input logic [1:0] ptr
    );
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!rr_pick[2] && req[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            eff_req[i] = '0;
            unique case (state_q[i])
                IDLE: begin
                    if (req_valid[i]) begin
                        eff_req[i] = req_target[NUM_PORTS*i +: NUM_PORTS];
                    end
                end
                SERVE:   eff_req[i] = remain_q[i];
                default: eff_req[i] = '0;
            endcase
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            col_req[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                col_req[j][i] = eff_req[i][j];
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            out_free[j] = !out_valid[j] || out_ready[j];
            gnt_any[j]  = 1'b0;
            gnt_idx[j]  = 2'd0;
            if (out_free[j]) begin
                {gnt_any[j], gnt_idx[j]} = rr_pick(col_req[j], ptr_q[j]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_PORTS; j++) begin
            gnt_data[j] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (gnt_idx[j] == 2'(i)) begin
                    gnt_data[j] = req_data[DATA_W*i +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            granted[i] = '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                granted[i][j] = gnt_any[j] && (gnt_idx[j] == 2'(i));
            end
        end
    end

    always_comb begin
        drop_n = 3'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i]  = state_q[i];
            remain_d[i] = remain_q[i];
            pop[i]      = (state_q[i] == POPWAIT) && req_valid[i];
            unique case (state_q[i])
                IDLE: begin
                    if (req_valid[i]) begin
                        remain_d[i] = req_target[NUM_PORTS*i +: NUM_PORTS]
                                    & ~granted[i];
                        if (req_target[NUM_PORTS*i +: NUM_PORTS] == '0) begin
                            state_d[i] = POPWAIT;
                            drop_n     = drop_n + 3'd1;
                        end else if (remain_d[i] == '0) begin
                            state_d[i] = POPWAIT;
                        end else begin
                            state_d[i] = SERVE;
                        end
                    end
                end
                SERVE: begin
                    remain_d[i] = remain_q[i] & ~granted[i];
                    if (remain_d[i] == '0) begin
                        state_d[i] = POPWAIT;
                    end
                end
                POPWAIT: state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    assign drop_sum = {1'b0, drop_cnt} + 17'(drop_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i]  <= IDLE;
                remain_q[i] <= '0;
                ptr_q[i]    <= 2'd3;
            end
            out_valid <= '0;
            out_data  <= '0;
            out_src   <= '0;
            drop_cnt  <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i]  <= state_d[i];
                remain_q[i] <= remain_d[i];
            end
            // A busy output keeps its beat; a free idle one drops valid.
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (out_free[j]) begin
                    if (gnt_any[j]) begin
                        out_valid[j]                 <= 1'b1;
                        out_data[DATA_W*j +: DATA_W] <= gnt_data[j];
                        out_src[2*j +: 2]            <= gnt_idx[j];
                        ptr_q[j]                     <= gnt_idx[j];
                    end else begin
                        out_valid[j] <= 1'b0;
                    end
                end
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

endmodule

// File: tb/tb_switch_xbar_scheduler.sv
// Directed bench for switch_xbar_scheduler with hand-computed expectations.
module tb_switch_xbar_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_target;
    logic [31:0] req_data;
    logic [3:0]  pop;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_src;
    logic [15:0] drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    switch_xbar_scheduler #(.NUM_PORTS(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_data   (req_data),
        .pop        (pop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] tgt,
                           input logic [7:0] d);
        req_target[4*i +: 4] = tgt;
        req_data[8*i +: 8]   = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0;
        req_target = 16'h0;
        req_data   = 32'h0;
        out_ready  = 4'hF;
        step();
        step();
        check("rst_pop", 32'(pop), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_src", 32'(out_src), 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);
        rst = 1'b0;

        // unicast
        set_req(0, 4'b0100, 8'hA5);
        req_valid = 4'b0001;
        step();
        check("uni_valid", 32'(out_valid), 32'h4);
        check("uni_data", 32'(out_data[23:16]), 32'hA5);
        check("uni_src", 32'(out_src[5:4]), 32'h0);
        check("uni_pop", 32'(pop), 32'h1);
        step();
        req_valid = 4'b0;
        check("uni_pop2", 32'(pop), 32'h0);
        check("uni_clr", 32'(out_valid), 32'h0);

        // broadcast with output 3 held busy
        out_ready = 4'b0111;
        set_req(0, 4'b1000, 8'h11);
        req_valid = 4'b0001;
        step();
        check("bc_pre_v", 32'(out_valid), 32'h8);
        check("bc_pre_pop", 32'(pop), 32'h1);
        set_req(1, 4'b1111, 8'h5C);
        req_valid = 4'b0011;
        step();
        req_valid = 4'b0010;
        check("bc_v", 32'(out_valid), 32'hF);
        check("bc_src3", 32'(out_src[7:6]), 32'h0);
        check("bc_d3", 32'(out_data[31:24]), 32'h11);
        check("bc_src0", 32'(out_src[1:0]), 32'h1);
        check("bc_src2", 32'(out_src[5:4]), 32'h1);
        check("bc_d2", 32'(out_data[23:16]), 32'h5C);
        check("bc_pop", 32'(pop), 32'h0);
        step();
        check("bc_hold_v", 32'(out_valid), 32'h8);
        check("bc_hold_src", 32'(out_src[7:6]), 32'h0);
        check("bc_hold_pop", 32'(pop), 32'h0);
        out_ready = 4'hF;
        step();
        check("bc_src3b", 32'(out_src[7:6]), 32'h1);
        check("bc_d3b", 32'(out_data[31:24]), 32'h5C);
        check("bc_pop1", 32'(pop), 32'h2);
        check("bc_v3", 32'(out_valid), 32'h8);
        step();
        req_valid = 4'b0;
        check("bc_pop_once", 32'(pop), 32'h0);
        check("bc_clr", 32'(out_valid), 32'h0);

        // zero target drop
        set_req(2, 4'b0000, 8'hEE);
        req_valid = 4'b0100;
        step();
        check("z_pop", 32'(pop), 32'h4);
        check("z_valid", 32'(out_valid), 32'h0);
        check("z_drop", 32'(drop_cnt), 32'h1);
        step();
        req_valid = 4'b0;
        check("z_pop2", 32'(pop), 32'h0);
        for (int i = 0; i < 4; i++) set_req(i, 4'b0000, 8'h00);
        req_valid = 4'hF;
        step();
        check("z_pop4", 32'(pop), 32'hF);
        check("z_drop5", 32'(drop_cnt), 32'h5);
        repeat (33000) @(posedge clk);
        #1;
        check("z_sat", 32'(drop_cnt), 32'hFFFF);
        check("z_sat_v", 32'(out_valid), 32'h0);
        req_valid = 4'b0;

        // round robin on output 0
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 4'b0001, 8'(i + 8'h40));
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_src", 32'(out_src[1:0]), 32'(k % 4));
            check("rr_data", 32'(out_data[7:0]), 32'(8'h40 + (k % 4)));
            check("rr_v", 32'(out_valid[0]), 32'h1);
        end

        // backpressure on output 1
        do_reset();
        set_req(0, 4'b0010, 8'h3C);
        set_req(1, 4'b0001, 8'h77);
        set_req(2, 4'b0010, 8'h99);
        set_req(3, 4'b0000, 8'h00);
        req_valid = 4'b0111;
        out_ready = 4'b1101;
        step();
        check("bp_v", 32'(out_valid), 32'h3);
        check("bp_d1", 32'(out_data[15:8]), 32'h3C);
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) req_valid = 4'b0110;
            check("bp_hold_d", 32'(out_data[15:8]), 32'h3C);
            check("bp_hold_s", 32'(out_src[3:2]), 32'h0);
            check("bp_hold_v", 32'(out_valid[1]), 32'h1);
            check("bp_out0_v", 32'(out_valid[0]), 32'(c % 2));
            check("bp_out0_d", 32'(out_data[7:0]), 32'h77);
            check("bp_pop2", 32'(pop[2]), 32'h0);
        end
        out_ready = 4'hF;
        step();
        check("bp_rel_d", 32'(out_data[15:8]), 32'h99);
        check("bp_rel_s", 32'(out_src[3:2]), 32'h2);
        check("bp_rel_pop", 32'(pop), 32'h6);

        // reset during a partially delivered multicast
        do_reset();
        out_ready = 4'b0111;
        set_req(0, 4'b1000, 8'h11);
        req_valid = 4'b0001;
        step();
        set_req(3, 4'b1001, 8'hD3);
        req_valid = 4'b1001;
        step();
        req_valid = 4'b1000;
        check("mr_src0", 32'(out_src[1:0]), 32'h3);
        step();
        check("mr_pre_v", 32'(out_valid), 32'h8);
        check("mr_pre_pop", 32'(pop), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("mr_rst_v", 32'(out_valid), 32'h0);
        check("mr_rst_pop", 32'(pop), 32'h0);
        check("mr_rst_src", 32'(out_src), 32'h0);
        step();
        rst = 1'b0;
        out_ready = 4'hF;
        set_req(0, 4'b0001, 8'hA0);
        set_req(1, 4'b0001, 8'hB1);
        req_valid = 4'b0011;
        step();
        check("mr_first_src", 32'(out_src[1:0]), 32'h0);
        check("mr_first_d", 32'(out_data[7:0]), 32'hA0);
        check("mr_v", 32'(out_valid), 32'h1);
        check("mr_pop", 32'(pop), 32'h1);
        check("mr_drop", 32'(drop_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
